// File: rtl/pe_pkg.sv
// Shared types and overflow helpers for the pe_mac_v2 processing element.
package pe_pkg;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  localparam int WIDE_W = 64;
  typedef logic [WIDE_W-1:0] wide_t;

  typedef struct packed {
    logic valid;
    logic clear;
    logic last;
    logic is_signed;
    logic sat;
  } op_tag_t;

  function automatic wide_t sat_max(input int w, input logic s);
    wide_t one;
    one = wide_t'(1);
    return s ? (one << (w - 1)) - one : (one << w) - one;
  endfunction

  // Signed min is returned sign-extended; callers truncate to w bits.
  function automatic wide_t sat_min(input int w, input logic s);
    wide_t one;
    one = wide_t'(1);
    return s ? ~((one << (w - 1)) - one) : '0;
  endfunction

  function automatic wide_t clamp(
    input wide_t val,
    input logic  ovf,
    input logic  neg,
    input int    w,
    input logic  s
  );
    if (!ovf) return val;
    return neg ? sat_min(w, s) : sat_max(w, s);
  endfunction

endpackage

// File: rtl/pe_mul_stage.sv
// Operand extension and multiply, with an optional product register.
module pe_mul_stage
  import pe_pkg::*;
#(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int ACC_WIDTH = 24,
  parameter int PIPE_MUL  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [A_WIDTH-1:0]   a_i,
  input  logic [B_WIDTH-1:0]   b_i,
  input  op_tag_t              tag_i,
  output logic [ACC_WIDTH:0]   prod_o,
  output op_tag_t              tag_o
);

  typedef logic signed [ACC_WIDTH:0] prod_t;

  logic signed [A_WIDTH:0] a_x;
  logic signed [B_WIDTH:0] b_x;
  prod_t                   prod_d;

  assign a_x = {tag_i.is_signed & a_i[A_WIDTH-1], a_i};
  assign b_x = {tag_i.is_signed & b_i[B_WIDTH-1], b_i};

  // ACC_WIDTH+1 signed bits always hold the exact product.
  assign prod_d = prod_t'(a_x) * prod_t'(b_x);

  if (PIPE_MUL != 0) begin : g_pipe
    logic [ACC_WIDTH:0] prod_q;
    op_tag_t            tag_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prod_q <= '0;
        tag_q  <= '0;
      end else begin
        prod_q <= prod_d;
        tag_q  <= tag_i;
      end
    end

    assign prod_o = prod_q;
    assign tag_o  = tag_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign prod_o = prod_d;
    assign tag_o  = tag_i;
  end

endmodule

// File: rtl/pe_mac_v2.sv
// Output-stationary systolic MAC PE with operand forwarding,
// signed/unsigned saturating accumulate and a drain chain.
module pe_mac_v2
  import pe_pkg::*;
#(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int ACC_WIDTH = 24,
  parameter int CNT_WIDTH = 8,
  parameter int PIPE_MUL  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_mode,
  input  logic                 saturate,
  input  logic [A_WIDTH-1:0]   a_in,
  input  logic [B_WIDTH-1:0]   b_in,
  input  logic                 valid_in,
  input  logic                 clear_in,
  input  logic                 last_in,
  output logic [A_WIDTH-1:0]   a_out,
  output logic [B_WIDTH-1:0]   b_out,
  output logic                 valid_out,
  output logic                 clear_out,
  output logic                 last_out,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic [CNT_WIDTH-1:0] mac_cnt,
  output logic                 sat_flag,
  input  logic [ACC_WIDTH-1:0] drain_in,
  input  logic                 drain_in_valid,
  input  logic                 shift_en,
  output logic [ACC_WIDTH-1:0] drain_out,
  output logic                 drain_out_valid,
  output logic                 overrun
);

  logic [A_WIDTH-1:0]   a_q;
  logic [B_WIDTH-1:0]   b_q;
  logic                 valid_q, clear_q, last_q;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 flag_q, flag_d;

  logic [ACC_WIDTH-1:0] drain_q, drain_d;
  logic                 dv_q, dv_d;
  logic [ACC_WIDTH-1:0] pend_q, pend_d;
  logic                 pfull_q, pfull_d;
  logic                 ovr_q, ovr_d;

  op_tag_t              tag_in, op;
  logic [ACC_WIDTH:0]   prod, base_x, sum_x;
  logic                 ovf, neg, cap;
  logic [ACC_WIDTH-1:0] res_sat, res;

  assign tag_in = '{
    valid:     valid_in,
    clear:     clear_in,
    last:      last_in,
    is_signed: signed_mode,
    sat:       saturate
  };

  pe_mul_stage #(
    .A_WIDTH  (A_WIDTH),
    .B_WIDTH  (B_WIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .PIPE_MUL (PIPE_MUL)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .a_i   (a_in),
    .b_i   (b_in),
    .tag_i (tag_in),
    .prod_o(prod),
    .tag_o (op)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      clear_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      a_q     <= a_in;
      b_q     <= b_in;
      valid_q <= valid_in;
      clear_q <= clear_in;
      last_q  <= last_in;
    end
  end

  // A clear-tagged op starts from zero, so one adder covers both cases.
  assign base_x = op.clear ? '0
                : {op.is_signed & acc_q[ACC_WIDTH-1], acc_q};
  assign sum_x  = base_x + prod;

  assign ovf = op.is_signed
             ? (sum_x[ACC_WIDTH] ^ sum_x[ACC_WIDTH-1])
             : sum_x[ACC_WIDTH];
  assign neg = op.is_signed & sum_x[ACC_WIDTH];

  assign res_sat = ACC_WIDTH'(clamp(
    wide_t'(sum_x[ACC_WIDTH-1:0]), ovf, neg, ACC_WIDTH, op.is_signed));
  assign res = op.sat ? res_sat : sum_x[ACC_WIDTH-1:0];

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (op.valid) begin
      acc_d  = res;
      flag_d = (flag_q & ~op.clear) | ovf;
      if (op.clear) begin
        cnt_d = CNT_WIDTH'(1);
      end else if (!(&cnt_q)) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end else if (op.clear) begin
      acc_d  = '0;
      cnt_d  = '0;
      flag_d = 1'b0;
    end
  end

  assign cap = op.valid & op.last;

  // The pending slot parks a result while the chain is busy shifting.
  always_comb begin
    drain_d = drain_q;
    dv_d    = dv_q;
    pend_d  = pend_q;
    pfull_d = pfull_q;
    ovr_d   = ovr_q;
    if (shift_en) begin
      drain_d = drain_in;
      dv_d    = drain_in_valid;
      if (cap) begin
        if (pfull_q) begin
          ovr_d = 1'b1;
        end else begin
          pend_d  = res;
          pfull_d = 1'b1;
        end
      end
    end else if (pfull_q) begin
      drain_d = pend_q;
      dv_d    = 1'b1;
      if (cap) begin
        pend_d = res;
      end else begin
        pfull_d = 1'b0;
      end
    end else if (cap) begin
      drain_d = res;
      dv_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      drain_q <= '0;
      dv_q    <= 1'b0;
      pend_q  <= '0;
      pfull_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      drain_q <= drain_d;
      dv_q    <= dv_d;
      pend_q  <= pend_d;
      pfull_q <= pfull_d;
      ovr_q   <= ovr_d;
    end
  end

  assign a_out           = a_q;
  assign b_out           = b_q;
  assign valid_out       = valid_q;
  assign clear_out       = clear_q;
  assign last_out        = last_q;
  assign acc_out         = acc_q;
  assign mac_cnt         = cnt_q;
  assign sat_flag        = flag_q;
  assign drain_out       = drain_q;
  assign drain_out_valid = dv_q;
  assign overrun         = ovr_q;

endmodule

// File: tb/tb_pe_mac_v2.sv
// Bench for pe_mac_v2: three configurations on one stimulus
// stream, checked against an arithmetic reference model.
module tb_pe_mac_v2;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_mode, saturate;
  logic [7:0]  a_in, b_in;
  logic        valid_in, clear_in, last_in;
  logic [23:0] drain_in;
  logic        drain_in_valid, shift_en;

  logic [7:0]  d0_a, d0_b, d2_a, d1_a_unused, d1_b_unused, d2_b_unused;
  logic        d0_v, d0_c, d0_l, d2_v;
  logic        d1_c_unused, d1_l_unused, d1_v_unused;
  logic        d2_c_unused, d2_l_unused;
  logic [23:0] d0_acc, d0_drn, d2_acc, d2_drn_unused;
  logic [15:0] d1_acc, d1_drn;
  logic [7:0]  d0_cnt, d1_cnt, d2_cnt;
  logic        d0_flg, d1_flg, d2_flg;
  logic        d0_dv, d1_dv, d2_dv_unused;
  logic        d0_ovr, d1_ovr, d2_ovr_unused;

  always #5 clk = ~clk;

  pe_mac_v2 u_d0 (
    .clk(clk), .rst(rst), .signed_mode(signed_mode), .saturate(saturate),
    .a_in(a_in), .b_in(b_in), .valid_in(valid_in), .clear_in(clear_in),
    .last_in(last_in), .a_out(d0_a), .b_out(d0_b), .valid_out(d0_v),
    .clear_out(d0_c), .last_out(d0_l), .acc_out(d0_acc), .mac_cnt(d0_cnt),
    .sat_flag(d0_flg), .drain_in(drain_in), .drain_in_valid(drain_in_valid),
    .shift_en(shift_en), .drain_out(d0_drn), .drain_out_valid(d0_dv),
    .overrun(d0_ovr)
  );

  pe_mac_v2 #(.ACC_WIDTH(16)) u_d1 (
    .clk(clk), .rst(rst), .signed_mode(signed_mode), .saturate(saturate),
    .a_in(a_in), .b_in(b_in), .valid_in(valid_in), .clear_in(clear_in),
    .last_in(last_in), .a_out(d1_a_unused), .b_out(d1_b_unused),
    .valid_out(d1_v_unused), .clear_out(d1_c_unused), .last_out(d1_l_unused),
    .acc_out(d1_acc), .mac_cnt(d1_cnt), .sat_flag(d1_flg),
    .drain_in(drain_in[15:0]), .drain_in_valid(drain_in_valid),
    .shift_en(shift_en), .drain_out(d1_drn), .drain_out_valid(d1_dv),
    .overrun(d1_ovr)
  );

  pe_mac_v2 #(.PIPE_MUL(1)) u_d2 (
    .clk(clk), .rst(rst), .signed_mode(signed_mode), .saturate(saturate),
    .a_in(a_in), .b_in(b_in), .valid_in(valid_in), .clear_in(clear_in),
    .last_in(last_in), .a_out(d2_a), .b_out(d2_b_unused), .valid_out(d2_v),
    .clear_out(d2_c_unused), .last_out(d2_l_unused), .acc_out(d2_acc),
    .mac_cnt(d2_cnt), .sat_flag(d2_flg), .drain_in(drain_in),
    .drain_in_valid(drain_in_valid), .shift_en(shift_en),
    .drain_out(d2_drn_unused), .drain_out_valid(d2_dv_unused),
    .overrun(d2_ovr_unused)
  );

  typedef struct {
    longint acc;
    int     cnt;
    bit     flag;
    longint drn;
    bit     dv;
    longint pend;
    bit     pfull;
    bit     ovr;
  } mdl_t;

  mdl_t   m0, m1;
  longint p_acc;
  int     p_cnt;
  bit     p_flag;
  int     n_chk = 0;
  int     n_fail = 0;

  function automatic longint opv(logic [7:0] x);
    return signed_mode ? longint'($signed(x)) : longint'(x);
  endfunction

  // Value-level model: integer range checks, clamp, modular wrap.
  function automatic mdl_t mstep(mdl_t m, int w);
    longint mm, lo, hi, base, sum, r;
    bit     o, cap;
    mm  = longint'(1) << w;
    hi  = signed_mode ? mm / 2 - 1 : mm - 1;
    lo  = signed_mode ? -(mm / 2) : 0;
    r   = 0;
    cap = valid_in && last_in;
    if (valid_in) begin
      if (clear_in) base = 0;
      else if (signed_mode && m.acc >= mm / 2) base = m.acc - mm;
      else base = m.acc;
      sum = base + opv(a_in) * opv(b_in);
      o = (sum > hi) || (sum < lo);
      if (o && saturate) sum = (sum > hi) ? hi : lo;
      r = ((sum % mm) + mm) % mm;
      m.acc  = r;
      m.flag = (clear_in ? 1'b0 : m.flag) | o;
      m.cnt  = clear_in ? 1 : (m.cnt < 255 ? m.cnt + 1 : 255);
    end else if (clear_in) begin
      m.acc = 0; m.cnt = 0; m.flag = 0;
    end
    if (shift_en) begin
      m.drn = longint'(drain_in) % mm;
      m.dv  = drain_in_valid;
      if (cap) begin
        if (m.pfull) m.ovr = 1;
        else begin m.pend = r; m.pfull = 1; end
      end
    end else if (m.pfull) begin
      m.drn = m.pend; m.dv = 1;
      if (cap) m.pend = r;
      else m.pfull = 0;
    end else if (cap) begin
      m.drn = r; m.dv = 1;
    end
    return m;
  endfunction

  task automatic mrst();
    m0 = '{default: 0};
    m1 = '{default: 0};
    p_acc = 0; p_cnt = 0; p_flag = 0;
  endtask

  task automatic drive(logic sg, logic st, logic [7:0] a, logic [7:0] b,
                       logic v, logic c, logic l, logic sh,
                       logic [23:0] din, logic dinv);
    signed_mode = sg; saturate = st; a_in = a; b_in = b;
    valid_in = v; clear_in = c; last_in = l; shift_en = sh;
    drain_in = din; drain_in_valid = dinv;
  endtask

  task automatic idle();
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 24'h0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    p_acc = m0.acc; p_cnt = m0.cnt; p_flag = m0.flag;
    m0 = mstep(m0, 24);
    m1 = mstep(m1, 16);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    mrst();
    #3;
    n_chk++;
    if ({d0_acc, d0_cnt, d0_flg, d0_drn, d0_dv, d0_ovr} !== '0) begin
      n_fail++;
      $display("FAIL reset_d0 got acc=%0h cnt=%0h drn=%0h want 0",
               d0_acc, d0_cnt, d0_drn);
    end
    n_chk++;
    if ({d0_a, d0_b, d0_v, d0_c, d0_l, d2_acc} !== '0) begin
      n_fail++;
      $display("FAIL reset_fwd got a=%0h b=%0h v=%0b d2acc=%0h want 0",
               d0_a, d0_b, d0_v, d2_acc);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_signed_pipe();
    drive(1, 0, 8'd3, 8'd4, 1, 1, 0, 0, 24'h0, 0);
    tick();
    n_chk++;
    if (d0_acc !== 24'd12) begin
      n_fail++; $display("FAIL sgn_acc1 got %0h want c", d0_acc);
    end
    n_chk++;
    if (d2_acc !== 24'd0 || d2_a !== 8'd3 || d2_v !== 1'b1) begin
      n_fail++;
      $display("FAIL pipe_c1 got acc=%0h a=%0h v=%0b want 0 3 1",
               d2_acc, d2_a, d2_v);
    end
    drive(1, 0, 8'hFE, 8'd5, 1, 0, 0, 0, 24'h0, 0);
    tick();
    n_chk++;
    if (d0_acc !== 24'd2 || d2_acc !== 24'd12) begin
      n_fail++;
      $display("FAIL sgn_acc2 got d0=%0h d2=%0h want 2 c", d0_acc, d2_acc);
    end
    drive(1, 0, 8'd7, 8'hFF, 1, 0, 1, 0, 24'h0, 0);
    tick();
    n_chk++;
    if (d0_acc !== 24'hFFFFFB || d0_cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL sgn_acc3 got acc=%0h cnt=%0d want fffffb 3",
               d0_acc, d0_cnt);
    end
    n_chk++;
    if (d0_drn !== 24'hFFFFFB || d0_dv !== 1'b1) begin
      n_fail++;
      $display("FAIL sgn_drain got %0h/%0b want fffffb/1", d0_drn, d0_dv);
    end
    idle();
    tick();
    n_chk++;
    if (d2_acc !== 24'hFFFFFB || d2_cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL pipe_acc3 got acc=%0h cnt=%0d want fffffb 3",
               d2_acc, d2_cnt);
    end
  endtask

  task automatic test_unsigned_wrap();
    drive(0, 0, 8'hFF, 8'hFF, 1, 1, 0, 0, 24'h0, 0);
    tick();
    drive(0, 0, 8'hFF, 8'hFF, 1, 0, 0, 0, 24'h0, 0);
    tick();
    n_chk++;
    if (d1_acc !== 16'd64514 || d1_flg !== 1'b1) begin
      n_fail++;
      $display("FAIL uwrap got acc=%0d flag=%0b want 64514 1", d1_acc, d1_flg);
    end
    drive(0, 1, 8'hFF, 8'hFF, 1, 1, 0, 0, 24'h0, 0);
    tick();
    n_chk++;
    if (d1_acc !== 16'd65025 || d1_flg !== 1'b0) begin
      n_fail++;
      $display("FAIL uclr got acc=%0d flag=%0b want 65025 0", d1_acc, d1_flg);
    end
    drive(0, 1, 8'hFF, 8'hFF, 1, 0, 0, 0, 24'h0, 0);
    tick();
    n_chk++;
    if (d1_acc !== 16'hFFFF || d1_flg !== 1'b1) begin
      n_fail++;
      $display("FAIL usat got acc=%0h flag=%0b want ffff 1", d1_acc, d1_flg);
    end
  endtask

  task automatic test_signed_sat();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 8'h80, 8'h7F, 1, (i == 0), 0, 0, 24'h0, 0);
      tick();
    end
    n_chk++;
    if (d1_acc !== 16'h8000 || d1_flg !== 1'b1) begin
      n_fail++;
      $display("FAIL ssat got acc=%0h flag=%0b want 8000 1", d1_acc, d1_flg);
    end
    drive(1, 1, 8'd1, 8'd1, 1, 1, 0, 0, 24'h0, 0);
    tick();
    n_chk++;
    if (d1_acc !== 16'd1 || d1_flg !== 1'b0) begin
      n_fail++;
      $display("FAIL ssat_clr got acc=%0h flag=%0b want 1 0", d1_acc, d1_flg);
    end
  endtask

  task automatic test_drain_collision();
    drive(1, 0, 8'd3, 8'd4, 1, 1, 1, 1, 24'h55, 1);
    tick();
    n_chk++;
    if (d0_drn !== 24'h55 || d0_dv !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_shift got %0h/%0b want 55/1", d0_drn, d0_dv);
    end
    idle();
    tick();
    n_chk++;
    if (d0_drn !== 24'd12 || d0_dv !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_pend got %0h/%0b want c/1", d0_drn, d0_dv);
    end
    drive(1, 0, 8'd2, 8'd2, 1, 1, 1, 1, 24'h0, 0);
    tick();
    n_chk++;
    if (d0_dv !== 1'b0 || d0_ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_fill got dv=%0b ovr=%0b want 0 0", d0_dv, d0_ovr);
    end
    drive(1, 0, 8'd5, 8'd5, 1, 1, 1, 1, 24'h0, 0);
    tick();
    n_chk++;
    if (d0_ovr !== 1'b1) begin
      n_fail++; $display("FAIL overrun got %0b want 1", d0_ovr);
    end
    idle();
    tick();
    n_chk++;
    if (d0_drn !== 24'd4 || d0_dv !== 1'b1 || d0_ovr !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_kept got %0h/%0b ovr=%0b want 4/1 1",
               d0_drn, d0_dv, d0_ovr);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 8'd9, 8'd9, 1, 1, 0, 0, 24'h0, 0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({d0_acc, d0_cnt, d0_flg, d0_drn, d0_dv, d0_ovr, d2_acc} !== '0) begin
      n_fail++;
      $display("FAIL arst got acc=%0h cnt=%0h ovr=%0b d2=%0h want 0",
               d0_acc, d0_cnt, d0_ovr, d2_acc);
    end
    n_chk++;
    if ({d0_a, d0_b, d0_v, d0_c, d0_l} !== '0) begin
      n_fail++;
      $display("FAIL arst_fwd got a=%0h b=%0h v=%0b want 0", d0_a, d0_b, d0_v);
    end
    mrst();
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 8'd2, 8'd3, 1, 1, 0, 0, 24'h0, 0);
    tick();
    n_chk++;
    if (d0_acc !== 24'd6 || d0_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL arst_new got acc=%0h cnt=%0d want 6 1", d0_acc, d0_cnt);
    end
  endtask

  task automatic test_cnt_sat();
    drive(0, 0, 8'd0, 8'd1, 1, 1, 0, 0, 24'h0, 0);
    tick();
    drive(0, 0, 8'd0, 8'd1, 1, 0, 0, 0, 24'h0, 0);
    for (int i = 0; i < 300; i++) tick();
    n_chk++;
    if (d0_cnt !== 8'd255 || d1_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL cnt_sat got %0d/%0d want 255", d0_cnt, d1_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
            8'($urandom), 8'($urandom),
            $urandom_range(9, 0) < 7, $urandom_range(19, 0) < 3,
            $urandom_range(4, 0) == 0, $urandom_range(9, 0) < 4,
            24'($urandom), $urandom_range(1, 0) == 1);
      tick();
      n_chk++;
      if (d0_acc !== 24'(m0.acc) || d0_cnt !== 8'(m0.cnt)
          || d0_flg !== m0.flag) begin
        n_fail++;
        $display("FAIL rnd_d0_acc i=%0d got %0h/%0d/%0b want %0h/%0d/%0b",
                 i, d0_acc, d0_cnt, d0_flg, m0.acc, m0.cnt, m0.flag);
      end
      n_chk++;
      if (d0_drn !== 24'(m0.drn) || d0_dv !== m0.dv || d0_ovr !== m0.ovr) begin
        n_fail++;
        $display("FAIL rnd_d0_drn i=%0d got %0h/%0b/%0b want %0h/%0b/%0b",
                 i, d0_drn, d0_dv, d0_ovr, m0.drn, m0.dv, m0.ovr);
      end
      n_chk++;
      if (d1_acc !== 16'(m1.acc) || d1_cnt !== 8'(m1.cnt)
          || d1_flg !== m1.flag) begin
        n_fail++;
        $display("FAIL rnd_d1_acc i=%0d got %0h/%0d/%0b want %0h/%0d/%0b",
                 i, d1_acc, d1_cnt, d1_flg, m1.acc, m1.cnt, m1.flag);
      end
      n_chk++;
      if (d1_drn !== 16'(m1.drn) || d1_dv !== m1.dv || d1_ovr !== m1.ovr) begin
        n_fail++;
        $display("FAIL rnd_d1_drn i=%0d got %0h/%0b/%0b want %0h/%0b/%0b",
                 i, d1_drn, d1_dv, d1_ovr, m1.drn, m1.dv, m1.ovr);
      end
      n_chk++;
      if (d2_acc !== 24'(p_acc) || d2_cnt !== 8'(p_cnt)
          || d2_flg !== p_flag) begin
        n_fail++;
        $display("FAIL rnd_d2_acc i=%0d got %0h/%0d/%0b want %0h/%0d/%0b",
                 i, d2_acc, d2_cnt, d2_flg, p_acc, p_cnt, p_flag);
      end
      n_chk++;
      if (d0_a !== a_in || d0_b !== b_in || d0_v !== valid_in
          || d0_c !== clear_in || d0_l !== last_in || d2_a !== a_in) begin
        n_fail++;
        $display("FAIL rnd_fwd i=%0d got a=%0h b=%0h vcl=%0b%0b%0b want %0h %0h %0b%0b%0b",
                 i, d0_a, d0_b, d0_v, d0_c, d0_l,
                 a_in, b_in, valid_in, clear_in, last_in);
      end
    end
  endtask

  initial begin
    test_reset();
    test_signed_pipe();
    test_unsigned_wrap();
    test_signed_sat();
    test_drain_collision();
    test_async_reset();
    test_cnt_sat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_mac_v2.md
Name: pe_mac_v2

Overview:
Parametrised systolic processing element, the next generation of the team's 8-bit output-stationary MAC PE.
- Forwards A/B operands and their sideband tags (valid, clear, last) with 1-cycle latency.
- Accumulates into a wide accumulator in signed or unsigned mode, with optional saturation and an optional multiplier pipeline stage.
- On the last operand, captures the result into an output-stationary drain chain so a column of PEs can shift results out while the next tile is computed.

Parameters:
A_WIDTH, 8, A operand width
B_WIDTH, 8, B operand width
ACC_WIDTH, 24, accumulator/result width; must be >= A_WIDTH+B_WIDTH
CNT_WIDTH, 8, MAC-count width
PIPE_MUL, 0, 1 = register the product one extra cycle before accumulate

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
signed_mode  in  1  1 = operands two's complement, 0 = unsigned
saturate  in  1  1 = clamp on accumulate overflow, 0 = wrap
a_in  in  A_WIDTH  A operand from west
b_in  in  B_WIDTH  B operand from north
valid_in  in  1  operand pair valid
clear_in  in  1  start new accumulation
last_in  in  1  final operand of the tile
a_out  out  A_WIDTH  forwarded A (east)
b_out  out  B_WIDTH  forwarded B (south)
valid_out  out  1  forwarded valid
clear_out  out  1  forwarded clear
last_out  out  1  forwarded last
acc_out  out  ACC_WIDTH  live accumulator
mac_cnt  out  CNT_WIDTH  valid MACs since last clear, saturating
sat_flag  out  1  sticky: clamp or wrap overflow since last clear
drain_in  in  ACC_WIDTH  result from upstream PE in drain chain
drain_in_valid  in  1  upstream drain valid
shift_en  in  1  shift the drain chain this cycle
drain_out  out  ACC_WIDTH  drain register
drain_out_valid  out  1  drain register holds data
overrun  out  1  sticky: result dropped because pending slot full

Behaviour:
- Reset (async, rst=1): every output register and every internal register is 0, including the pending slot and the pipeline tags. Deasserting rst mid-tile discards all partial state.
- Forwarding: a_out, b_out, valid_out, clear_out and last_out each take the corresponding input every cycle, regardless of valid_in. Latency 1.
- Product:
  - Operands are sign-extended when signed_mode=1 and zero-extended otherwise.
  - Full A_WIDTH+B_WIDTH product is extended to ACC_WIDTH+1 bits for the overflow check.
  - signed_mode and saturate are sampled with the operands and travel with the op.
- Op stage: PIPE_MUL=0 → accumulate uses the current-cycle product. PIPE_MUL=1 → product, valid, clear, last and mode tags are registered once, so accumulator latency is 2 cycles.
- Accumulate, per op-stage cycle:
  - valid & clear: acc = prod, mac_cnt = 1, sat_flag cleared.
  - valid & !clear: acc = acc + prod, mac_cnt += 1, holding at all-ones.
  - !valid & clear: acc = 0, mac_cnt = 0, sat_flag = 0.
  - !valid & !clear: hold.
- Overflow:
  - Overflow is judged against the ACC_WIDTH range for the op's signedness.
  - saturate=1: result clamps to max or min (unsigned min is 0). saturate=0: result wraps.
  - Either case sets sat_flag. A clear-tagged op clears sat_flag and then sets it only if its own product overflows.
- Result capture: a valid & last op produces the new acc value R in the same cycle.
  - shift_en=0 and pending empty → drain_out = R, drain_out_valid = 1.
  - shift_en=1 → the drain register takes drain_in/drain_in_valid, and R goes to the 1-entry pending slot.
  - Pending already full → R is dropped and overrun = 1 (sticky until rst).
- Drain:
  - shift_en=1: drain_out = drain_in, drain_out_valid = drain_in_valid.
  - shift_en=0 and pending full: drain register loads pending, drain_out_valid = 1, pending empties.
  - Otherwise hold.
  - When a result completes with shift_en=0 while pending is full, pending moves to the drain register and R becomes the new pending entry; no drop.
- Accumulator and drain paths are independent; back-to-back tiles are legal.

Decomposition:
- Package pe_pkg:
  - mode constants (MODE_UNSIGNED/MODE_SIGNED)
  - op-tag struct (valid, clear, last, signed, sat)
  - functions sat_max/sat_min(width, signed)
  - the clamp function
- One sub-module, pe_mul_stage: extends operands, multiplies, and optionally registers product plus tags (PIPE_MUL). Accumulator, counter and drain stay in pe_mac_v2.

Test Plan:
- Signed, PIPE_MUL=0: ops (3,4,clear) then (-2,5) then (7,-1,last) → acc 12, 2, -5; drain_out=-5 and drain_out_valid=1 the cycle after last; mac_cnt=3.
- Unsigned wrap, ACC_WIDTH=16: repeated 255×255 with saturate=0 → after 2 ops acc = 130050 mod 65536 = 64514 and sat_flag=1. Same with saturate=1 → acc = 65535.
- Signed saturate, ACC_WIDTH=16: (-128)×127 accumulated 3 times → acc clamps to -32768; next clear-tagged op 1×1 → acc=1, sat_flag=0.
- PIPE_MUL=1: identical stream to scenario 1 → identical acc sequence shifted 1 cycle later; a_out/b_out/valid_out still 1-cycle latency.
- Drain collision: last completes with shift_en=1 and drain_in=0x55, drain_in_valid=1 → drain_out=0x55, then R appears on the first shift_en=0 cycle. A second last while pending is full and shift_en=1 → overrun=1.
- Async reset mid-tile: assert rst with no clk edge → all outputs 0 immediately. Release → a new clear-tagged op starts cleanly.
